axi_ram_rd: RTL
===============

AXI_RAM_RD -- requirements
Module: axi_ram_rd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, R-channel data width (fixed 32 in this revision).
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 6, log2 of memory depth in 32-bit words (64 words).
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports s_axi_arid/araddr/arlen/arsize/arburst/arcache, input, 8/32/8/3/2/4, AXI4 read address payload; arcache ignored.
REQ-006 SHALL have ports s_axi_arvalid input 1 and s_axi_arready output 1, AR handshake.
REQ-007 SHALL have ports s_axi_rid/rdata/rresp/rlast/rvalid, output, 8/32/2/1/1, and s_axi_rready, input, 1, AXI4 R channel.
REQ-008 SHALL have ports mem_we input 1, mem_waddr input MEM_ADDR_WIDTH, mem_wdata input 32: backdoor word write for preload.

Function
REQ-009 SHALL implement FSM states IDLE and BURST; IDLE->BURST on AR handshake (arvalid&&arready); BURST->IDLE on handshake of beat with rlast=1.
REQ-010 SHALL drive s_axi_arready=1 only in IDLE; arready drops on the edge that accepts AR and returns 1 on the edge of the last-beat R handshake (new AR accepted no earlier than the following cycle).
REQ-011 SHALL register arid, araddr, arlen, arsize, arburst at AR handshake; rid equals captured arid for every beat.
REQ-012 SHALL assert rvalid on the first edge after AR handshake (1-cycle latency) with beat 0; each subsequent beat valid on the edge after the previous R handshake when rready was 1 (full throughput, 1 beat/cycle).
REQ-013 SHALL hold rid/rdata/rresp/rlast stable while rvalid=1 and rready=0.
REQ-014 SHALL issue exactly arlen+1 beats; rlast=1 only on beat arlen; 8-bit beat counter, arlen=255 yields 256 beats.
REQ-015 SHALL return rdata = mem[addr[MEM_ADDR_WIDTH+1:2]] for current beat address (word-aligned fetch; low 2 address bits ignored for data).
REQ-016 SHALL advance beat address: FIXED (2'b00) unchanged; INCR (2'b01) += 1<<arsize, 32-bit wraparound at 2^32; reserved (2'b11) returns SLVERR every beat.
REQ-017 SHALL return rresp=SLVERR (2'b10), rdata=0 for all beats when arsize>2.
REQ-018 SHALL return rresp=DECERR (2'b11), rdata=0 for any beat whose address >= 4*2^MEM_ADDR_WIDTH; other beats of same burst OKAY (2'b00).
REQ-019 SHALL apply mem_we writes at the edge; a write and read of the same word in the same cycle returns the old data for a beat registered that edge.

Reset
REQ-020 SHALL, while rst=0, force state IDLE, s_axi_arready=0, s_axi_rvalid=0, s_axi_rlast=0, rid=0, rdata=0, rresp=0, beat counter 0, asynchronously.
REQ-021 SHALL set arready=1 on first rising edge after rst deasserts.
REQ-022 SHALL abandon an in-flight burst on reset without further beats; memory contents not cleared.

Configuration
REQ-023 SHALL, with macro AXI_RAM_RD_WRAP_EN defined, support WRAP (2'b10): arlen+1 in {2,4,8,16}, boundary=(arlen+1)<<arsize, address wraps to aligned boundary base; other lengths give SLVERR all beats.
REQ-024 SHALL, without AXI_RAM_RD_WRAP_EN, return SLVERR, rdata=0 for every beat of any WRAP burst, beat count and rlast unchanged.

Verification
REQ-025 SHALL cover: preload mem[i]=0xA000_0000+i; AR INCR addr 0x10 len 3 size 2 id 0x5, rready=1 -> rdata A0000004..A0000007, rid 0x5, OKAY, rlast on 4th, rvalid 1 cycle after AR.
REQ-026 SHALL cover: same burst with rready toggled 1/0 -> payload held during stall, no beat skipped or duplicated.
REQ-027 SHALL cover: FIXED addr 0x08 len 2 -> three beats all A0000002; INCR addr 0xF8 len 3 -> beats 0,1 OKAY, beats 2,3 DECERR rdata 0.
REQ-028 SHALL cover: WRAP addr 0x0C len 3 size 2 -> with AXI_RAM_RD_WRAP_EN words 3,0,1,2 OKAY; without, 4 beats SLVERR.
REQ-029 SHALL cover: arsize=3 -> all beats SLVERR; rst pulsed low mid-burst -> rvalid=0 immediately, arready=1 one edge after release, next burst correct.

Source files
------------

// File: rtl/axi_ram_rd.sv
// AXI4 read-only slave over a 2^MEM_ADDR_WIDTH-word RAM with a backdoor preload port.
// Latency: beat 0 is registered on the AR handshake edge; then one beat per cycle. Stalls hold the R payload.
// Optional WRAP burst support is compiled in with AXI_RAM_RD_WRAP_EN.
module axi_ram_rd #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                s_axi_arid,
    input  logic [31:0]               s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic [3:0]                s_axi_arcache,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [7:0]                s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    input  logic                      mem_we,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata
);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;

    logic ar_hs, r_hs, load;
    logic [31:0] f_addr, step, next_addr;
    logic [7:0]  f_len;
    logic [2:0]  f_size;
    logic [1:0]  f_burst;
    logic        wrap_ok, slverr, decerr;
    logic [1:0]  beat_resp;
    logic [DATA_WIDTH-1:0] beat_data;
    logic        unused_cache;

    assign unused_cache = ^s_axi_arcache;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;
    assign load  = ar_hs || (r_hs && !s_axi_rlast);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = BURST;
            BURST:   if (r_hs && s_axi_rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat 0 is evaluated straight from the AR payload; later beats from the captured copy.
    assign f_addr  = (state == IDLE) ? s_axi_araddr  : addr_q;
    assign f_len   = (state == IDLE) ? s_axi_arlen   : len_q;
    assign f_size  = (state == IDLE) ? s_axi_arsize  : size_q;
    assign f_burst = (state == IDLE) ? s_axi_arburst : burst_q;
    assign step    = 32'd1 << f_size;

`ifdef AXI_RAM_RD_WRAP_EN
    logic [31:0] wmask;
    assign wmask   = ((32'd0 | f_len) + 32'd1 << f_size) - 32'd1;
    assign wrap_ok = (f_len == 8'd1) || (f_len == 8'd3) || (f_len == 8'd7) || (f_len == 8'd15);
`else
    assign wrap_ok = 1'b0;
`endif

    assign slverr = (f_size > 3'd2) || (f_burst == 2'b11) || ((f_burst == 2'b10) && !wrap_ok);
    assign decerr = |f_addr[31:MEM_ADDR_WIDTH+2];

    always_comb begin
        beat_resp = 2'b00;
        beat_data = mem[f_addr[MEM_ADDR_WIDTH+1:2]];
        if (slverr) begin
            beat_resp = 2'b10;
            beat_data = '0;
        end else if (decerr) begin
            beat_resp = 2'b11;
            beat_data = '0;
        end
    end

    always_comb begin
        next_addr = f_addr;
        case (f_burst)
            2'b01:   next_addr = f_addr + step;
`ifdef AXI_RAM_RD_WRAP_EN
            2'b10:   next_addr = (f_addr & ~wmask) | ((f_addr + step) & wmask);
`endif
            default: next_addr = f_addr;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= '0;
            cnt           <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            size_q        <= '0;
            burst_q       <= '0;
        end else begin
            s_axi_arready <= (state_nxt == IDLE);
            if (ar_hs) begin
                s_axi_rid    <= s_axi_arid;
                len_q        <= s_axi_arlen;
                size_q       <= s_axi_arsize;
                burst_q      <= s_axi_arburst;
                cnt          <= '0;
                s_axi_rlast  <= (s_axi_arlen == 8'd0);
                s_axi_rvalid <= 1'b1;
            end else if (r_hs) begin
                if (s_axi_rlast) begin
                    s_axi_rvalid <= 1'b0;
                    s_axi_rlast  <= 1'b0;
                end else begin
                    cnt         <= cnt + 8'd1;
                    s_axi_rlast <= ((cnt + 8'd1) == len_q);
                end
            end
            if (load) begin
                s_axi_rdata <= beat_data;
                s_axi_rresp <= beat_resp;
                addr_q      <= next_addr;
            end
        end
    end
endmodule
